// File: rtl/beat_packer.sv
// Packs RATIO narrow valid/ready beats into one wide word and pushes it into a FIFO push/full port.
// Optional macro BEAT_PACKER_TIMEOUT_EN force-closes a partial word after TIMEOUT_CYCLES idle cycles.
module beat_packer #(
    parameter int IN_WIDTH       = 8,
    parameter int RATIO          = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int OUT_WIDTH      = IN_WIDTH * RATIO,
    parameter int CNT_WIDTH      = $clog2(RATIO)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [IN_WIDTH-1:0]  in_data_i,
    input  logic                 in_last_i,
    output logic                 push_o,
    output logic [OUT_WIDTH-1:0] data_o,
    output logic [RATIO-1:0]     mask_o,
    input  logic                 full_i,
    output logic [CNT_WIDTH-1:0] fill_o
);

    generate
        if (RATIO < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
            $error("beat_packer: RATIO must be >= 2 and TIMEOUT_CYCLES >= 1");
        end
    endgenerate

    logic [OUT_WIDTH-1:0] acc_q, acc_d, out_q, out_d;
    logic [RATIO-1:0]     acc_mask_q, acc_mask_d, out_mask_q, out_mask_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 out_valid_q, out_valid_d;

    logic                 stage_free, accept, lane_last, fire, complete;
    logic [OUT_WIDTH-1:0] acc_word;
    logic [RATIO-1:0]     acc_word_mask;

    // The staging slot can take a new word if it is empty or being pushed this cycle.
    assign stage_free = ~out_valid_q | ~full_i;
    assign in_ready_o = ~flush_i & stage_free;
    assign accept     = in_valid_i & in_ready_o;
    assign push_o     = out_valid_q & ~full_i & ~flush_i;
    assign lane_last  = (cnt_q == CNT_WIDTH'(RATIO - 1));

    assign data_o = out_q;
    assign mask_o = out_mask_q;
    assign fill_o = cnt_q;

    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_lane
            logic hit;
            assign hit = accept & (cnt_q == CNT_WIDTH'(gi));
            assign acc_word[gi*IN_WIDTH +: IN_WIDTH] = hit ? in_data_i : acc_q[gi*IN_WIDTH +: IN_WIDTH];
            assign acc_word_mask[gi] = hit | acc_mask_q[gi];
        end
    endgenerate

`ifdef BEAT_PACKER_TIMEOUT_EN
    localparam int IDLE_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    logic [IDLE_WIDTH-1:0] idle_q, idle_d;
    logic                  idle_cond;

    assign idle_cond = (cnt_q != '0) & ~accept;
    // Fires on the edge the counter would reach TIMEOUT_CYCLES; saturates while staging is blocked.
    assign fire = idle_cond & ~flush_i & stage_free &
                  (idle_q >= IDLE_WIDTH'(TIMEOUT_CYCLES - 1));

    always_comb begin
        idle_d = idle_q;
        if (flush_i || accept || fire) begin
            idle_d = '0;
        end else if (idle_cond && idle_q != IDLE_WIDTH'(TIMEOUT_CYCLES)) begin
            idle_d = idle_q + IDLE_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign fire = 1'b0;
`endif

    assign complete = (accept & (lane_last | in_last_i)) | fire;

    always_comb begin
        acc_d       = acc_q;
        acc_mask_d  = acc_mask_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_mask_d  = out_mask_q;
        out_valid_d = out_valid_q;
        if (flush_i) begin
            acc_d       = '0;
            acc_mask_d  = '0;
            cnt_d       = '0;
            out_d       = '0;
            out_mask_d  = '0;
            out_valid_d = 1'b0;
        end else if (complete) begin
            // Reloading the staging slot here keeps back-to-back words bubble-free.
            out_d       = acc_word;
            out_mask_d  = acc_word_mask;
            out_valid_d = 1'b1;
            acc_d       = '0;
            acc_mask_d  = '0;
            cnt_d       = '0;
        end else begin
            if (push_o) begin
                out_valid_d = 1'b0;
            end
            if (accept) begin
                acc_d      = acc_word;
                acc_mask_d = acc_word_mask;
                cnt_d      = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q       <= '0;
            acc_mask_q  <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            out_mask_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            acc_mask_q  <= acc_mask_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_mask_q  <= out_mask_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_beat_packer.sv
// Bench for beat_packer: directed vectors, a queue-based reference model checked every cycle,
// and literal expectations on the captured push log.
module tb_beat_packer;
    localparam int W  = 8;
    localparam int R  = 4;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       full = 1'b0;
    logic [7:0] in_data = '0;
    logic        in_ready, push;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [1:0]  fill;

    beat_packer #(.IN_WIDTH(W), .RATIO(R), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_last_i(in_last),
        .push_o(push), .data_o(data), .mask_o(mask), .full_i(full), .fill_o(fill)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Push log: {mask, data} of every word the DUT hands to the FIFO, with its cycle number.
    logic [35:0] log_q[$];
    int          log_cyc[$];

    task automatic chk_log(input string name, input int idx, input logic [35:0] exp);
        if (idx < log_q.size()) chk(name, 64'(log_q[idx]), 64'(exp));
        else chk(name, 64'hDEAD_0000_0000, 64'(exp));
    endtask

    // Reference model: beats of the open word in a queue, plus one staged word.
    logic [7:0]  m_beats[$];
    bit          m_staged;
    logic [31:0] m_out;
    logic [3:0]  m_out_mask;
    int          m_idle;
    bit          e_ready, e_push, e_acc, e_free;

    function automatic void m_clear();
        m_beats.delete();
        m_staged   = 1'b0;
        m_out      = '0;
        m_out_mask = '0;
        m_idle     = 0;
    endfunction

    function automatic void m_close();
        m_out = '0;
        for (int i = 0; i < m_beats.size(); i++) m_out = m_out | (32'(m_beats[i]) << (8 * i));
        m_out_mask = 4'((1 << m_beats.size()) - 1);
        m_staged   = 1'b1;
        m_beats.delete();
        m_idle     = 0;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            m_clear();
        end else begin
            e_free  = !m_staged || !full;
            e_ready = !flush && e_free;
            e_push  = m_staged && !full && !flush;
            chk("cyc_in_ready", 64'(in_ready), 64'(e_ready));
            chk("cyc_push", 64'(push), 64'(e_push));
            chk("cyc_data", 64'(data), 64'(m_out));
            chk("cyc_mask", 64'(mask), 64'(m_out_mask));
            chk("cyc_fill", 64'(fill), 64'(m_beats.size()));
            if (push) begin
                log_q.push_back({mask, data});
                log_cyc.push_back(cyc);
            end
            if (flush) begin
                m_clear();
            end else begin
                e_acc = in_valid && e_ready;
                if (e_push) m_staged = 1'b0;
                if (e_acc) begin
                    m_beats.push_back(in_data);
                    m_idle = 0;
                    if (m_beats.size() == R || in_last) m_close();
                end
`ifdef BEAT_PACKER_TIMEOUT_EN
                else if (m_beats.size() != 0) begin
                    if (m_idle >= TO - 1 && e_free) m_close();
                    else if (m_idle < TO) m_idle++;
                end
`endif
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    int c0;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_push", 64'(push), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_data", 64'(data), 64'd0);
        chk("rst_mask", 64'(mask), 64'd0);
        chk("rst_fill", 64'(fill), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // Full word, one-cycle latency
        log_q.delete(); log_cyc.delete();
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        idle(0);
        chk("t1_push_latency", 64'(push), 64'd1);
        chk("t1_data_now", 64'(data), 64'h4433_2211);
        idle(2);
        chk("t1_log_size", 64'(log_q.size()), 64'd1);
        chk_log("t1_word", 0, {4'b1111, 32'h4433_2211});
        chk("t1_fill", 64'(fill), 64'd0);
        $display("txn full_word data=%08h mask=%b", 32'h4433_2211, 4'b1111);

        // Single beat with last
        log_q.delete(); log_cyc.delete();
        send(8'hAA, 1);
        idle(0);
        chk("t2_push", 64'(push), 64'd1);
        chk("t2_data", 64'(data), 64'h0000_00AA);
        chk("t2_mask", 64'(mask), 64'b0001);
        idle(2);
        $display("txn single_last data=%08h mask=%b", 32'h0000_00AA, 4'b0001);

        // Three beats closed by last
        log_q.delete(); log_cyc.delete();
        send(8'h10, 0); send(8'h20, 0); send(8'h30, 1);
        idle(2);
        chk_log("t2b_word", 0, {4'b0111, 32'h0030_2010});
        $display("txn partial_last data=%08h mask=%b", 32'h0030_2010, 4'b0111);

        // Back-to-back words, no bubble
        log_q.delete(); log_cyc.delete();
        for (int i = 1; i <= 8; i++) begin
            chk("t3_ready", 64'(in_ready), 64'd1);
            send(8'(i), 0);
        end
        idle(2);
        chk("t3_log_size", 64'(log_q.size()), 64'd2);
        chk_log("t3_word0", 0, {4'b1111, 32'h0403_0201});
        chk_log("t3_word1", 1, {4'b1111, 32'h0807_0605});
        if (log_cyc.size() == 2) chk("t3_spacing", 64'(log_cyc[1] - log_cyc[0]), 64'd4);
        else chk("t3_spacing", 64'hFFFF, 64'd4);
        $display("txn back_to_back words=%0d", log_q.size());

        // Backpressure
        log_q.delete(); log_cyc.delete();
        full = 1'b1;
        send(8'hA1, 0); send(8'hA2, 0); send(8'hA3, 0); send(8'hA4, 0);
        in_data = 8'h99;
        in_last = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("t4_push_held", 64'(push), 64'd0);
            chk("t4_ready_held", 64'(in_ready), 64'd0);
            chk("t4_data_stable", 64'(data), 64'hA4A3_A2A1);
            @(posedge clk); #1;
        end
        chk("t4_fill_held", 64'(fill), 64'd0);
        in_valid = 1'b0;
        full = 1'b0;
        #1;
        chk("t4_push_release", 64'(push), 64'd1);
        chk("t4_ready_release", 64'(in_ready), 64'd1);
        idle(2);
        chk("t4_log_size", 64'(log_q.size()), 64'd1);
        $display("txn backpressure data=%08h", 32'hA4A3_A2A1);

        // Flush mid-word
        log_q.delete(); log_cyc.delete();
        send(8'h11, 0); send(8'h22, 0);
        in_data = 8'h77;
        flush = 1'b1;
        #1;
        chk("t5_flush_push", 64'(push), 64'd0);
        chk("t5_flush_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t5_fill_after", 64'(fill), 64'd0);
        send(8'h33, 0); send(8'h44, 0); send(8'h55, 0); send(8'h66, 0);
        idle(2);
        chk("t5_log_size", 64'(log_q.size()), 64'd1);
        chk_log("t5_word", 0, {4'b1111, 32'h6655_4433});
        $display("txn flush data=%08h", 32'h6655_4433);

        // Reset mid-word
        log_q.delete(); log_cyc.delete();
        send(8'h11, 0); send(8'h22, 0);
        idle(0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("t6_rst_fill", 64'(fill), 64'd0);
        rst_n = 1'b1;
        idle(3);
        chk("t6_no_push", 64'(log_q.size()), 64'd0);
        $display("txn reset_mid_word pushes=%0d", log_q.size());

        // Idle partial word
        log_q.delete(); log_cyc.delete();
        send(8'h11, 0); send(8'h22, 0);
        c0 = cyc;
        idle(100);
`ifdef BEAT_PACKER_TIMEOUT_EN
        chk("t7_log_size", 64'(log_q.size()), 64'd1);
        chk_log("t7_word", 0, {4'b0011, 32'h0000_2211});
        if (log_cyc.size() > 0) chk("t7_push_cycle", 64'(log_cyc[0] - c0), 64'd16);
        else chk("t7_push_cycle", 64'hFFFF, 64'd16);
`else
        chk("t7_no_push", 64'(log_q.size()), 64'd0);
        chk("t7_fill_kept", 64'(fill), 64'd2);
`endif
        $display("txn idle_partial pushes=%0d", log_q.size());
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        idle(2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
